mem_port_arbiter: RTL and testbench

- Shares the single-port, 16-bit-word on-chip memory between two requesters: instruction fetch (IF, read-only) and data load/store (D, read/write).
- Sits between the CPU front end / load-store unit and the memory block.
- Issues at most one memory access per cycle and returns read data one cycle after grant, matching the memory's registered read.
- Provides fixed priority to D with a starvation guard for IF, and range-checks addresses against the memory depth.

---
 rtl/mem_arb_pkg.sv | 23 ++
 rtl/mem_port_arbiter_if.sv | 42 ++++
 rtl/mem_arb_starve_ctr.sv | 28 ++
 rtl/mem_port_arbiter.sv | 119 +++++++++++
 tb/tb_mem_port_arbiter.sv | 235 +++++++++++++++++++++++
 5 files changed

// File: rtl/mem_arb_pkg.sv
// Shared constants and helpers for the two-requester memory port arbiter.
package mem_arb_pkg;

    localparam int WORD_W = 16;
    localparam int ADDR_W = 16;

    typedef logic [1:0] owner_t;

    // Which requester the next response belongs to
    localparam owner_t OWN_NONE = 2'd0;
    localparam owner_t OWN_IF   = 2'd1;
    localparam owner_t OWN_D    = 2'd2;

    localparam int unsigned DEF_MEM_DEPTH  = 1000;
    localparam int unsigned DEF_STARVE_MAX = 4;

    // True when a word address falls inside the populated memory
    function automatic logic addr_in_range(input logic [ADDR_W-1:0] addr,
                                           input int unsigned depth);
        return ({16'd0, addr} < depth);
    endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundle of requester-side and memory-side signals around the arbiter.
interface mem_port_arbiter_if;
    import mem_arb_pkg::*;

    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_gnt;
    logic              if_rvalid;
    logic [WORD_W-1:0] if_rdata;
    logic              if_err;

    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [WORD_W-1:0] d_wdata;
    logic              d_gnt;
    logic              d_rvalid;
    logic [WORD_W-1:0] d_rdata;
    logic              d_err;

    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [WORD_W-1:0] mem_data_in;
    logic [WORD_W-1:0] mem_data_out;

    // Requesters plus memory: drives requests and memory read data
    modport master (
        output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_data_out,
        input  if_gnt, if_rvalid, if_rdata, if_err,
               d_gnt, d_rvalid, d_rdata, d_err,
               mem_we, mem_addr, mem_data_in
    );

    // Arbiter side
    modport slave (
        input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_data_out,
        output if_gnt, if_rvalid, if_rdata, if_err,
               d_gnt, d_rvalid, d_rdata, d_err,
               mem_we, mem_addr, mem_data_in
    );

endinterface

// File: rtl/mem_arb_starve_ctr.sv
// Saturating count of D grants taken while IF keeps waiting.
module mem_arb_starve_ctr #(
    parameter int unsigned MAX = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic inc,
    input  logic clr,
    output logic max_hit
);

    localparam logic [3:0] MAX_C = 4'(MAX);

    logic [3:0] cnt;

    // Clear wins over increment; the count sticks at MAX until cleared
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt <= 4'd0;
        else if (clr)
            cnt <= 4'd0;
        else if (inc && (cnt != MAX_C))
            cnt <= cnt + 4'd1;
    end

    assign max_hit = (cnt == MAX_C);

endmodule

// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter: D has priority, IF is forced through after
// STARVE_MAX consecutive D wins, out-of-range addresses get an error reply.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned MEM_DEPTH  = DEF_MEM_DEPTH,
    parameter int unsigned STARVE_MAX = DEF_STARVE_MAX
) (
    input logic            clk,
    input logic            rst_n,
    mem_port_arbiter_if.slave bus
);

    logic              if_gnt_c;
    logic              d_gnt_c;
    logic              any_gnt;
    logic [ADDR_W-1:0] gnt_addr;
    logic              gnt_in_range;
    logic              gnt_access;
    logic              max_hit;

    logic [ADDR_W-1:0] last_addr;
    logic [ADDR_W-1:0] mem_addr_c;
    owner_t            rsp_owner;
    logic              rsp_err;
    owner_t            rsp_owner_next;

    logic              if_rvalid_c;
    logic              d_rvalid_c;
    logic [WORD_W-1:0] if_rdata_c;
    logic [WORD_W-1:0] d_rdata_c;
    logic [WORD_W-1:0] if_rdata_q;
    logic [WORD_W-1:0] d_rdata_q;

    mem_arb_starve_ctr #(.MAX(STARVE_MAX)) u_starve (
        .clk     (clk),
        .rst_n   (rst_n),
        .inc     (d_gnt_c && bus.if_req),
        .clr     (if_gnt_c || !bus.if_req),
        .max_hit (max_hit)
    );

    // Fixed priority to D unless IF has waited out its starvation budget
    always_comb begin
        if_gnt_c = 1'b0;
        d_gnt_c  = 1'b0;
        if (bus.d_req && bus.if_req) begin
            if (max_hit)
                if_gnt_c = 1'b1;
            else
                d_gnt_c = 1'b1;
        end else if (bus.d_req) begin
            d_gnt_c = 1'b1;
        end else if (bus.if_req) begin
            if_gnt_c = 1'b1;
        end
    end

    assign any_gnt      = if_gnt_c || d_gnt_c;
    assign gnt_addr     = d_gnt_c ? bus.d_addr : bus.if_addr;
    assign gnt_in_range = addr_in_range(gnt_addr, MEM_DEPTH);
    assign gnt_access   = any_gnt && gnt_in_range;

    assign bus.if_gnt      = if_gnt_c;
    assign bus.d_gnt       = d_gnt_c;
    assign mem_addr_c      = gnt_access ? gnt_addr : last_addr;
    assign bus.mem_addr    = mem_addr_c;
    assign bus.mem_we      = gnt_access && d_gnt_c && bus.d_we;
    assign bus.mem_data_in = gnt_access ? bus.d_wdata : '0;

    // Decide who gets a reply next cycle; in-range writes get none
    always_comb begin
        rsp_owner_next = OWN_NONE;
        if (if_gnt_c)
            rsp_owner_next = OWN_IF;
        else if (d_gnt_c && (!bus.d_we || !gnt_in_range))
            rsp_owner_next = OWN_D;
    end

    // Response tracking and the held memory address
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_owner <= OWN_NONE;
            rsp_err   <= 1'b0;
            last_addr <= '0;
        end else begin
            rsp_owner <= rsp_owner_next;
            rsp_err   <= any_gnt && !gnt_in_range;
            last_addr <= mem_addr_c;
        end
    end

    assign if_rvalid_c = (rsp_owner == OWN_IF);
    assign d_rvalid_c  = (rsp_owner == OWN_D);

    // Read data passes straight from the memory's output register during the
    // valid cycle and is otherwise held from the last response
    assign if_rdata_c = if_rvalid_c ? (rsp_err ? '0 : bus.mem_data_out) : if_rdata_q;
    assign d_rdata_c  = d_rvalid_c  ? (rsp_err ? '0 : bus.mem_data_out) : d_rdata_q;

    // Hold registers behind the read data outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            if_rdata_q <= '0;
            d_rdata_q  <= '0;
        end else begin
            if_rdata_q <= if_rdata_c;
            d_rdata_q  <= d_rdata_c;
        end
    end

    assign bus.if_rvalid = if_rvalid_c;
    assign bus.d_rvalid  = d_rvalid_c;
    assign bus.if_rdata  = if_rdata_c;
    assign bus.d_rdata   = d_rdata_c;
    assign bus.if_err    = if_rvalid_c && rsp_err;
    assign bus.d_err     = d_rvalid_c && rsp_err;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a registered-read memory model.
module tb_mem_port_arbiter;
    import mem_arb_pkg::*;

    logic clk;
    logic rst_n;
    int   pass_cnt;
    int   total_cnt;

    logic [15:0] mem [0:1023];

    mem_port_arbiter_if bus ();

    mem_port_arbiter #(.MEM_DEPTH(1000), .STARVE_MAX(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory model: registered read, write on mem_we
    always @(posedge clk) begin
        if (bus.mem_we)
            mem[bus.mem_addr[9:0]] <= bus.mem_data_in;
        bus.mem_data_out <= mem[bus.mem_addr[9:0]];
    end

    task automatic chk(input string name, input logic [15:0] got, input logic [15:0] exp);
        total_cnt++;
        if (got !== exp)
            $display("[TB] FAIL %s: got %h expected %h", name, got, exp);
        else
            pass_cnt++;
    endtask

    task automatic idle();
        bus.if_req  = 1'b0;
        bus.if_addr = '0;
        bus.d_req   = 1'b0;
        bus.d_we    = 1'b0;
        bus.d_addr  = '0;
        bus.d_wdata = '0;
    endtask

    task automatic test_reset();
        idle();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_if_rvalid", 16'(bus.if_rvalid), 16'h0);
        chk("rst_d_rvalid",  16'(bus.d_rvalid),  16'h0);
        chk("rst_if_err",    16'(bus.if_err),    16'h0);
        chk("rst_d_err",     16'(bus.d_err),     16'h0);
        chk("rst_if_rdata",  bus.if_rdata,       16'h0000);
        chk("rst_d_rdata",   bus.d_rdata,        16'h0000);
        chk("rst_mem_we",    16'(bus.mem_we),    16'h0);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_if_single();
        @(negedge clk);
        bus.if_req = 1'b1; bus.if_addr = 16'd0;
        #1;
        chk("if1_gnt",    16'(bus.if_gnt), 16'h1);
        chk("if1_d_gnt",  16'(bus.d_gnt),  16'h0);
        chk("if1_addr",   bus.mem_addr,    16'h0000);
        chk("if1_we",     16'(bus.mem_we), 16'h0);
        @(negedge clk);
        bus.if_req = 1'b0;
        chk("if1_rvalid", 16'(bus.if_rvalid), 16'h1);
        chk("if1_rdata",  bus.if_rdata,       16'h1000);
        chk("if1_err",    16'(bus.if_err),    16'h0);
        chk("if1_d_rv",   16'(bus.d_rvalid),  16'h0);
        @(negedge clk);
        chk("if1_rv_off", 16'(bus.if_rvalid), 16'h0);
        chk("if1_hold",   bus.if_rdata,       16'h1000);
    endtask

    task automatic test_starvation();
        logic prev_if;
        prev_if = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (i > 0) begin
                if (prev_if) begin
                    chk("stv_if_rv",   16'(bus.if_rvalid), 16'h1);
                    chk("stv_if_data", bus.if_rdata,       16'h1000);
                end else begin
                    chk("stv_d_rv",    16'(bus.d_rvalid),  16'h1);
                    chk("stv_d_data",  bus.d_rdata,        16'h0014);
                end
            end
            bus.if_req = 1'b1; bus.if_addr = 16'd0;
            bus.d_req  = 1'b1; bus.d_we = 1'b0; bus.d_addr = 16'd20;
            #1;
            chk($sformatf("stv_if_gnt%0d", i), 16'(bus.if_gnt), 16'((i % 5) == 4));
            chk($sformatf("stv_d_gnt%0d", i),  16'(bus.d_gnt),  16'((i % 5) != 4));
            prev_if = ((i % 5) == 4);
        end
        @(negedge clk);
        idle();
        chk("stv_last_if_rv", 16'(bus.if_rvalid), 16'h1);
        chk("stv_last_d_rv",  16'(bus.d_rvalid),  16'h0);
        chk("stv_last_data",  bus.if_rdata,       16'h1000);
    endtask

    task automatic test_write_read();
        @(negedge clk);
        bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_addr = 16'd50; bus.d_wdata = 16'hBEEF;
        #1;
        chk("wr_gnt",  16'(bus.d_gnt),  16'h1);
        chk("wr_we",   16'(bus.mem_we), 16'h1);
        chk("wr_addr", bus.mem_addr,    16'd50);
        chk("wr_data", bus.mem_data_in, 16'hBEEF);
        @(negedge clk);
        chk("wr_no_rsp", 16'(bus.d_rvalid), 16'h0);
        bus.d_we = 1'b0;
        #1;
        chk("rd_we", 16'(bus.mem_we), 16'h0);
        @(negedge clk);
        idle();
        chk("rd_rvalid", 16'(bus.d_rvalid), 16'h1);
        chk("rd_data",   bus.d_rdata,       16'hBEEF);
        chk("rd_err",    16'(bus.d_err),    16'h0);
    endtask

    task automatic test_out_of_range();
        // Last in-range word
        @(negedge clk);
        bus.d_req = 1'b1; bus.d_addr = 16'd999;
        @(negedge clk);
        idle();
        chk("oor999_err",  16'(bus.d_err), 16'h0);
        chk("oor999_data", bus.d_rdata,    16'h03E7);
        // D read at MEM_DEPTH
        @(negedge clk);
        bus.d_req = 1'b1; bus.d_addr = 16'd1000;
        #1;
        chk("oor_d_gnt",  16'(bus.d_gnt),  16'h1);
        chk("oor_d_we",   16'(bus.mem_we), 16'h0);
        chk("oor_d_hold", bus.mem_addr,    16'd999);
        @(negedge clk);
        idle();
        chk("oor_d_rv",   16'(bus.d_rvalid), 16'h1);
        chk("oor_d_err",  16'(bus.d_err),    16'h1);
        chk("oor_d_data", bus.d_rdata,       16'h0000);
        chk("oor_d_we2",  16'(bus.mem_we),   16'h0);
        // D write out of range
        @(negedge clk);
        bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_addr = 16'd2000; bus.d_wdata = 16'h5555;
        #1;
        chk("oor_w_we",   16'(bus.mem_we),      16'h0);
        chk("oor_w_din",  bus.mem_data_in,      16'h0000);
        @(negedge clk);
        idle();
        chk("oor_w_rv",   16'(bus.d_rvalid), 16'h1);
        chk("oor_w_err",  16'(bus.d_err),    16'h1);
        // IF read at top of address space
        @(negedge clk);
        bus.if_req = 1'b1; bus.if_addr = 16'hFFFF;
        #1;
        chk("oor_if_gnt", 16'(bus.if_gnt), 16'h1);
        chk("oor_if_we",  16'(bus.mem_we), 16'h0);
        @(negedge clk);
        idle();
        chk("oor_if_rv",   16'(bus.if_rvalid), 16'h1);
        chk("oor_if_err",  16'(bus.if_err),    16'h1);
        chk("oor_if_data", bus.if_rdata,       16'h0000);
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (i > 0) begin
                chk($sformatf("b2b_rv%0d", i),   16'(bus.if_rvalid), 16'h1);
                chk($sformatf("b2b_data%0d", i), bus.if_rdata,       16'(9 + i));
            end
            if (i < 3) begin
                bus.if_req = 1'b1; bus.if_addr = 16'(10 + i);
            end else begin
                idle();
            end
        end
        @(negedge clk);
        chk("b2b_rv_off", 16'(bus.if_rvalid), 16'h0);
    endtask

    task automatic test_reset_inflight();
        @(negedge clk);
        bus.if_req = 1'b1; bus.if_addr = 16'd5;
        #1;
        chk("rsf_gnt", 16'(bus.if_gnt), 16'h1);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        idle();
        @(negedge clk);
        chk("rsf_rv0", 16'(bus.if_rvalid), 16'h0);
        @(negedge clk);
        rst_n = 1'b1;
        chk("rsf_rv1",   16'(bus.if_rvalid), 16'h0);
        chk("rsf_rdata", bus.if_rdata,       16'h0000);
        @(negedge clk);
        chk("rsf_rv2", 16'(bus.if_rvalid), 16'h0);
        bus.if_req = 1'b1; bus.if_addr = 16'd2;
        @(negedge clk);
        idle();
        chk("rsf_rd_rv",   16'(bus.if_rvalid), 16'h1);
        chk("rsf_rd_data", bus.if_rdata,       16'h3000);
    endtask

    initial begin
        pass_cnt  = 0;
        total_cnt = 0;
        for (int i = 0; i < 1024; i++)
            mem[i] = 16'(i);
        mem[0] = 16'h1000;
        mem[1] = 16'h2000;
        mem[2] = 16'h3000;
        rst_n = 1'b0;
        idle();
        test_reset();
        test_if_single();
        test_starvation();
        test_write_read();
        test_out_of_range();
        test_back_to_back();
        test_reset_inflight();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
